// File: rtl/hpu_reset_distribution.sv
// Reset conditioning: syncs rst_in release to clk, fans out pipelined copies to next partition (rst_nxt) and local logic (rst_out).
// Latency: assert = async into sync + pipe edges; release = SYNC_STAGES-1 + pipe edges after the first edge seeing rst_in high.
// No backpressure. Define HPU_RESET_DIST_BUFG_EN to drive rst_out through a BUFG_FABRIC.
module hpu_reset_distribution #(
    parameter bit RST_POL         = 1'b0,
    parameter int SYNC_STAGES     = 2,
    parameter int INTER_PART_PIPE = 3,
    parameter int INTRA_PART_PIPE = 3
) (
    input  logic clk,
    input  logic rst_in,
    output logic rst_nxt,
    output logic rst_out
);

    // Active-high internally; power-up value is asserted so the part starts in reset.
    logic [SYNC_STAGES-1:0] sync_q = '1;
    logic                   rst_sync;
    logic                   sync_pol;
    logic                   out_last;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];
    assign sync_pol = rst_sync ^ ~RST_POL;

    // Pipelines carry the output polarity so the last flop drives the port directly.
    generate
        if (INTER_PART_PIPE == 0) begin : g_nxt_bypass
            assign rst_nxt = sync_pol;
        end else begin : g_nxt_pipe
            logic [INTER_PART_PIPE-1:0] nxt_q = {INTER_PART_PIPE{RST_POL}};
            always_ff @(posedge clk) begin
                nxt_q[0] <= sync_pol;
                for (int i = 1; i < INTER_PART_PIPE; i++) begin
                    nxt_q[i] <= nxt_q[i-1];
                end
            end
            assign rst_nxt = nxt_q[INTER_PART_PIPE-1];
        end

        if (INTRA_PART_PIPE == 0) begin : g_out_bypass
            assign out_last = sync_pol;
        end else begin : g_out_pipe
            logic [INTRA_PART_PIPE-1:0] out_q = {INTRA_PART_PIPE{RST_POL}};
            always_ff @(posedge clk) begin
                out_q[0] <= sync_pol;
                for (int i = 1; i < INTRA_PART_PIPE; i++) begin
                    out_q[i] <= out_q[i-1];
                end
            end
            assign out_last = out_q[INTRA_PART_PIPE-1];
        end
    endgenerate

`ifdef HPU_RESET_DIST_BUFG_EN
    BUFG_FABRIC u_bufg_fabric (
        .I (out_last),
        .O (rst_out)
    );
`else
    assign rst_out = out_last;
`endif

endmodule

// File: tb/tb_hpu_reset_distribution.sv
// Bench for hpu_reset_distribution: three configurations share clk/rst_in; a scoreboard of expected reset state
// per edge is pushed on each rising edge and popped at the following falling edge.
module tb_hpu_reset_distribution;

    logic clk    = 1'b0;
    logic rst_in = 1'b1;
    logic rst_nxt_a, rst_out_a;
    logic rst_nxt_p, rst_out_p;
    logic rst_nxt_z, rst_out_z;

    int checks = 0;
    int errors = 0;

    // low_seen bookkeeping: was rst_in low at any moment in the interval ending at this edge.
    int fall_cnt  = 0;
    int fall_seen = 0;
    bit low_hold  = 1'b1;
    bit ls_prev   = 1'b1;
    bit ls_cur    = 1'b1;
    bit q3[$];
    bit q7[$];

    always #5 clk = ~clk;

    hpu_reset_distribution #(.RST_POL(1'b0), .SYNC_STAGES(2), .INTER_PART_PIPE(3), .INTRA_PART_PIPE(3)) dut_a (
        .clk(clk), .rst_in(rst_in), .rst_nxt(rst_nxt_a), .rst_out(rst_out_a));
    hpu_reset_distribution #(.RST_POL(1'b1), .SYNC_STAGES(2), .INTER_PART_PIPE(3), .INTRA_PART_PIPE(3)) dut_p (
        .clk(clk), .rst_in(rst_in), .rst_nxt(rst_nxt_p), .rst_out(rst_out_p));
    hpu_reset_distribution #(.RST_POL(1'b0), .SYNC_STAGES(2), .INTER_PART_PIPE(0), .INTRA_PART_PIPE(7)) dut_z (
        .clk(clk), .rst_in(rst_in), .rst_nxt(rst_nxt_z), .rst_out(rst_out_z));

    always @(negedge rst_in) fall_cnt++;

    // With two sync stages, the value presented to a pipe at edge k is asserted iff rst_in was low
    // somewhere in the two intervals ending at edges k-1 and k.
    always @(posedge clk) begin
        ls_prev   = ls_cur;
        ls_cur    = low_hold | (fall_cnt != fall_seen) | ~rst_in;
        fall_seen = fall_cnt;
        low_hold  = ~rst_in;
        q3.push_back(ls_prev | ls_cur);
        q7.push_back(ls_prev | ls_cur);
    end

    bit         a3, a7, a0;
    logic [5:0] obs, exp_v;

    task automatic test_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #2;
            @(negedge clk);
            a3 = q3.pop_front(); a7 = q7.pop_front();
            a0 = ls_cur | low_hold | (fall_cnt != fall_seen);
            obs   = {rst_nxt_a, rst_out_a, rst_nxt_p, rst_out_p, rst_nxt_z, rst_out_z};
            exp_v = {~a3, ~a3, a3, a3, ~a0, ~a7};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset edge %0d got %b expected %b", c + 1, obs, exp_v);
            end
        end
        // Spec-level anchor: defaults deassert after exactly 5 edges from power-up.
        checks++;
        if ({rst_nxt_a, rst_out_a, rst_out_p} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release got %b expected 110", {rst_nxt_a, rst_out_a, rst_out_p});
        end
    endtask

    task automatic test_pulse();
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #2;
            if (c == 1)  rst_in = 1'b0;
            if (c == 11) rst_in = 1'b1;
            @(negedge clk);
            a3 = q3.pop_front(); a7 = q7.pop_front();
            a0 = ls_cur | low_hold | (fall_cnt != fall_seen);
            obs   = {rst_nxt_a, rst_out_a, rst_nxt_p, rst_out_p, rst_nxt_z, rst_out_z};
            exp_v = {~a3, ~a3, a3, a3, ~a0, ~a7};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pulse cyc %0d got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        int asserted_a = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #2;
            @(negedge clk);
            a3 = q3.pop_front(); a7 = q7.pop_front();
            a0 = ls_cur | low_hold | (fall_cnt != fall_seen);
            obs   = {rst_nxt_a, rst_out_a, rst_nxt_p, rst_out_p, rst_nxt_z, rst_out_z};
            exp_v = {~a3, ~a3, a3, a3, ~a0, ~a7};
            if (!rst_out_a) asserted_a++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL glitch cyc %0d got %b expected %b", c, obs, exp_v);
            end
            if (c == 2) begin
                #2 rst_in = 1'b0;
                #1 rst_in = 1'b1;
            end
        end
        checks++;
        if (asserted_a < 2) begin
            errors++;
            $display("FAIL glitch_width got %0d cycles expected at least 2", asserted_a);
        end
    endtask

    task automatic test_reassert();
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #2;
            if (c == 1) rst_in = 1'b0;
            if (c == 6) rst_in = 1'b1;
            if (c == 7) rst_in = 1'b0;
            if (c == 9) rst_in = 1'b1;
            @(negedge clk);
            a3 = q3.pop_front(); a7 = q7.pop_front();
            a0 = ls_cur | low_hold | (fall_cnt != fall_seen);
            obs   = {rst_nxt_a, rst_out_a, rst_nxt_p, rst_out_p, rst_nxt_z, rst_out_z};
            exp_v = {~a3, ~a3, a3, a3, ~a0, ~a7};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reassert cyc %0d got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_steady();
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #2;
            @(negedge clk);
            a3 = q3.pop_front(); a7 = q7.pop_front();
            a0 = ls_cur | low_hold | (fall_cnt != fall_seen);
            obs   = {rst_nxt_a, rst_out_a, rst_nxt_p, rst_out_p, rst_nxt_z, rst_out_z};
            exp_v = {~a3, ~a3, a3, a3, ~a0, ~a7};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL steady cyc %0d got %b expected %b", c, obs, exp_v);
            end
        end
        checks++;
        if (obs !== 6'b110011) begin
            errors++;
            $display("FAIL steady_final got %b expected 110011", obs);
        end
    endtask

    initial begin
        // Power-up fill of the pipes: asserted for depth-1 samples before the first real entry.
        q3.push_back(1'b1); q3.push_back(1'b1);
        for (int i = 0; i < 6; i++) q7.push_back(1'b1);
        test_reset();
        test_pulse();
        test_glitch();
        test_reassert();
        test_steady();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
